// File: rtl/scan_mux.sv
// Registered N:1 word multiplexer with several channels sharing one select.
// The select comes either from a loadable register (direct mode) or from a one-pass scan counter.
module scan_mux_lane #(
  parameter int WIDTH  = 8,
  parameter int INPUTS = 4,
  parameter int SELW   = 2
) (
  input  logic [INPUTS*WIDTH-1:0] din,
  input  logic [SELW-1:0]         idx,
  input  logic                    enb_n,
  output logic [WIDTH-1:0]        word
);
  logic [INPUTS-1:0][WIDTH-1:0] words;

  assign words = din;
  assign word  = enb_n ? '0 : words[idx];
endmodule

module scan_mux #(
  parameter  int WIDTH    = 8,
  parameter  int INPUTS   = 4,
  parameter  int CHANNELS = 2,
  localparam int SELW     = $clog2(INPUTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CHANNELS*INPUTS*WIDTH-1:0] din,
  input  logic [SELW-1:0]                  sel,
  input  logic                             sel_ld,
  input  logic [CHANNELS-1:0]              enb_n,
  input  logic                             mode,
  input  logic                             scan_start,
  output logic [CHANNELS*WIDTH-1:0]        q,
  output logic [SELW-1:0]                  q_sel,
  output logic                             q_valid,
  output logic                             scan_busy,
  output logic                             scan_done
);
  typedef enum logic {IDLE, SCAN} state_t;

  state_t                             state_q, state_d;
  logic [SELW-1:0]                    cnt_q, cnt_d;
  logic [SELW-1:0]                    sel_r_q, sel_r_d;
  logic [CHANNELS-1:0][WIDTH-1:0]     q_q, q_d;
  logic [SELW-1:0]                    q_sel_q, q_sel_d;
  logic                               q_valid_q, q_valid_d;
  logic                               done_q, done_d;
  logic [SELW-1:0]                    idx;
  logic [CHANNELS-1:0][WIDTH-1:0]     word;
  logic                               sample;

  // A scan only drives the index while mode stays high; dropping mode aborts to direct.
  assign idx = (mode && state_q == SCAN) ? cnt_q : sel_r_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    scan_mux_lane #(.WIDTH(WIDTH), .INPUTS(INPUTS), .SELW(SELW)) u_lane (
      .din   (din[c*INPUTS*WIDTH +: INPUTS*WIDTH]),
      .idx   (idx),
      .enb_n (enb_n[c]),
      .word  (word[c])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_r_d   = sel_ld ? sel : sel_r_q;
    q_d       = q_q;
    q_sel_d   = q_sel_q;
    q_valid_d = 1'b0;
    done_d    = 1'b0;
    sample    = 1'b0;
    if (!mode) begin
      state_d = IDLE;
      cnt_d   = '0;
      sample  = 1'b1;
    end else if (state_q == SCAN) begin
      sample = 1'b1;
      cnt_d  = cnt_q + SELW'(1);
      if (cnt_q == SELW'(INPUTS-1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (scan_start) begin
      state_d = SCAN;
      cnt_d   = '0;
    end
    if (sample) begin
      q_d       = word;
      q_sel_d   = idx;
      q_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_r_q   <= '0;
      q_q       <= '0;
      q_sel_q   <= '0;
      q_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_r_q   <= sel_r_d;
      q_q       <= q_d;
      q_sel_q   <= q_sel_d;
      q_valid_q <= q_valid_d;
      done_q    <= done_d;
    end
  end

  assign q         = q_q;
  assign q_sel     = q_sel_q;
  assign q_valid   = q_valid_q;
  assign scan_busy = (state_q == SCAN);
  assign scan_done = done_q;
endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: directed vector table for the multi-cycle scenarios, then random traffic vs a model.
module tb_scan_mux;
  localparam int W = 8, N = 4, C = 2, SW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [C*N*W-1:0]  din;
  logic [SW-1:0]     sel;
  logic              sel_ld;
  logic [C-1:0]      enb_n;
  logic              mode, scan_start;
  logic [C*W-1:0]    q;
  logic [SW-1:0]     q_sel;
  logic              q_valid, scan_busy, scan_done;

  always #5 clk = ~clk;

  scan_mux #(.WIDTH(W), .INPUTS(N), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset), .din(din), .sel(sel), .sel_ld(sel_ld), .enb_n(enb_n),
    .mode(mode), .scan_start(scan_start), .q(q), .q_sel(q_sel), .q_valid(q_valid),
    .scan_busy(scan_busy), .scan_done(scan_done)
  );

  typedef struct {
    logic rst; logic [1:0] sel; logic ld; logic [1:0] enb; logic md, st;
    logic [15:0] q; logic [1:0] qs; logic v, bz, dn;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0, n_bad = 0;

  // model state
  int          m_sel, m_pos;
  bit          m_scan, m_v, m_dn;
  logic [15:0] m_q;
  logic [1:0]  m_qs;

  function automatic vec_t mk(logic rst, logic [1:0] s, logic ld, logic [1:0] e, logic md, logic st,
                              logic [15:0] eq, logic [1:0] eqs, logic v, logic bz, logic dn);
    vec_t r;
    r.rst = rst; r.sel = s; r.ld = ld; r.enb = e; r.md = md; r.st = st;
    r.q = eq; r.qs = eqs; r.v = v; r.bz = bz; r.dn = dn;
    return r;
  endfunction

  task automatic apply(input logic r, input logic [1:0] s, input logic l, input logic [1:0] e,
                       input logic m, input logic st);
    reset = r; sel = s; sel_ld = l; enb_n = e; mode = m; scan_start = st;
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input int idx, input logic [20:0] got, input logic [20:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got q/q_sel/valid/busy/done=%h required %h", name, idx, got, exp);
    end
  endtask

  // Reference: sequence of scan positions and select-register value, evaluated per edge.
  task automatic model_step(input logic r, input logic [1:0] s, input logic l, input logic [1:0] e,
                            input logic m, input logic st, input logic [C*N*W-1:0] d);
    int src;
    if (r) begin
      m_sel = 0; m_scan = 0; m_pos = 0; m_q = '0; m_qs = '0; m_v = 0; m_dn = 0;
      return;
    end
    src = -1; m_v = 0; m_dn = 0;
    if (!m) begin
      m_scan = 0; src = m_sel;
    end else if (m_scan) begin
      src = m_pos; m_pos++;
      if (m_pos == N) begin m_scan = 0; m_dn = 1; end
    end else if (st) begin
      m_scan = 1; m_pos = 0;
    end
    if (src >= 0) begin
      m_v = 1; m_qs = 2'(src);
      for (int c = 0; c < C; c++)
        m_q[c*W +: W] = e[c] ? 8'h00 : 8'(d >> ((c*N + src)*W));
    end
    if (l) m_sel = int'(s);
  endtask

  initial begin
    reset = 1'b1; sel = '0; sel_ld = 1'b0; enb_n = '0; mode = 1'b0; scan_start = 1'b0;
    din = {8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h44, 8'h33, 8'h22, 8'h11};

    //                 rst sel ld enb   md st   q        qs v bz dn
    tbl.push_back(mk(1, 2, 0, 2'b00, 0, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2, 1, 2'b00, 0, 0, 16'hA111, 0, 1, 0, 0));
    tbl.push_back(mk(0, 2, 0, 2'b00, 0, 0, 16'hC333, 2, 1, 0, 0));
    tbl.push_back(mk(0, 2, 0, 2'b10, 0, 0, 16'h0033, 2, 1, 0, 0));
    tbl.push_back(mk(0, 2, 0, 2'b11, 0, 0, 16'h0000, 2, 1, 0, 0));
    tbl.push_back(mk(0, 2, 0, 2'b00, 1, 1, 16'h0000, 2, 0, 1, 0));
    tbl.push_back(mk(0, 2, 0, 2'b00, 1, 0, 16'hA111, 0, 1, 1, 0));
    tbl.push_back(mk(0, 2, 0, 2'b00, 1, 0, 16'hB222, 1, 1, 1, 0));
    tbl.push_back(mk(0, 2, 0, 2'b00, 1, 1, 16'hC333, 2, 1, 1, 0));
    tbl.push_back(mk(0, 2, 0, 2'b00, 1, 0, 16'hD444, 3, 1, 0, 1));
    tbl.push_back(mk(0, 2, 0, 2'b00, 1, 0, 16'hD444, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2, 0, 2'b00, 1, 1, 16'hD444, 3, 0, 1, 0));
    tbl.push_back(mk(0, 2, 0, 2'b00, 1, 0, 16'hA111, 0, 1, 1, 0));
    tbl.push_back(mk(0, 2, 0, 2'b00, 0, 0, 16'hC333, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2'b00, 0, 0, 16'hC333, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 0, 0, 16'hB222, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 1, 16'hB222, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 0, 16'hA111, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 0, 16'hB222, 1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 0, 2'b00, 1, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 1, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 0, 16'hA111, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 0, 16'hB222, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 0, 16'hC333, 2, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 0, 16'hD444, 3, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 1, 16'hD444, 3, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 1, 16'hA111, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 1, 16'hB222, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 1, 16'hC333, 2, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 1, 16'hD444, 3, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 1, 16'hD444, 3, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 1, 16'hA111, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 0, 16'hB222, 1, 1, 1, 0));

    @(negedge clk);
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].sel, tbl[i].ld, tbl[i].enb, tbl[i].md, tbl[i].st);
      check("vector", i, {q, q_sel, q_valid, scan_busy, scan_done},
            {tbl[i].q, tbl[i].qs, tbl[i].v, tbl[i].bz, tbl[i].dn});
    end

    // Random traffic; first cycle is a reset to align the model.
    for (int i = 0; i < 600; i++) begin
      logic r, l, m, st;
      logic [1:0] s, e;
      r  = (i == 0) || ($urandom_range(0, 99) < 3);
      s  = 2'($urandom);
      l  = ($urandom_range(0, 99) < 30);
      e  = 2'($urandom);
      m  = ($urandom_range(0, 99) < 75);
      st = ($urandom_range(0, 99) < 30);
      din = {$urandom, $urandom};
      model_step(r, s, l, e, m, st, din);
      apply(r, s, l, e, m, st);
      check("random", i, {q, q_sel, q_valid, scan_busy, scan_done}, {m_q, m_qs, m_v, m_scan, m_dn});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter WIDTH, default 8, data bits per input word.
REQ-002 Parameter INPUTS, default 4, words per channel; power of two, >= 2; SELW = log2(INPUTS).
REQ-003 Parameter CHANNELS, default 2, independent mux channels sharing one select.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 din  input  CHANNELS*INPUTS*WIDTH  data; word (c,i) at bits [(c*INPUTS+i)*WIDTH +: WIDTH].
REQ-007 sel  input  SELW  direct-mode select value.
REQ-008 sel_ld  input  1  load sel into select register.
REQ-009 enb_n  input  CHANNELS  per-channel enable, active low.
REQ-010 mode  input  1  0 = direct, 1 = scan.
REQ-011 scan_start  input  1  begin one scan pass (scan mode only).
REQ-012 q  output  CHANNELS*WIDTH  registered channel outputs; channel c at [c*WIDTH +: WIDTH].
REQ-013 q_sel  output  SELW  select index that produced the current q.
REQ-014 q_valid  output  1  q/q_sel hold a valid sample.
REQ-015 scan_busy  output  1  scan pass in progress.
REQ-016 scan_done  output  1  one-cycle pulse at end of a complete scan pass.

Function
REQ-017 Select register sel_r SHALL load sel on any edge with sel_ld=1, in either mode.
REQ-018 Direct mode: each edge SHALL register q[c] = enb_n[c] ? 0 : din(c, sel_r), q_sel = sel_r, q_valid = 1; latency one cycle from din/sel_r to q.
REQ-019 sel_ld and output register in the same edge: q SHALL use the old sel_r; the new value takes effect the following edge.
REQ-020 Scan FSM states: IDLE, SCAN; scan counter cnt of SELW bits.
REQ-021 IDLE -> SCAN on edge with mode=1 and scan_start=1; cnt <= 0.
REQ-022 In SCAN each edge SHALL register q[c] = enb_n[c] ? 0 : din(c, cnt), q_sel = cnt, q_valid = 1, then cnt <= cnt+1.
REQ-023 On the edge sampling cnt = INPUTS-1, FSM SHALL return to IDLE and assert scan_done for exactly the next cycle; cnt wraps to 0.
REQ-024 scan_start while in SCAN SHALL be ignored (no restart, no extension).
REQ-025 scan_busy SHALL be 1 exactly while FSM is in SCAN.
REQ-026 Scan mode in IDLE: q and q_sel SHALL hold last values; q_valid = 0.
REQ-027 mode falling to 0 during SCAN SHALL abort: FSM -> IDLE that edge, no scan_done, direct behaviour from that edge.
REQ-028 Disable is per channel and does not affect other channels, q_sel, q_valid or FSM.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 reset=1 at an edge SHALL force q=0, q_sel=0, q_valid=0, scan_busy=0, scan_done=0, sel_r=0, cnt=0, FSM=IDLE, overriding all other inputs including mid-scan.
REQ-031 First edge after reset deasserts SHALL behave per mode normally (direct: q_valid=1 at that edge).

Verification (WIDTH=8, INPUTS=4, CHANNELS=2)
REQ-032 Direct: ch0 words {11,22,33,44}, ch1 {A1,B2,C3,D4}, sel=2, sel_ld pulse -> two edges later q={C3,33}, q_sel=2, q_valid=1.
REQ-033 Disable: as REQ-032, enb_n=2'b10 -> q ch1=00, ch0=33; enb_n=2'b11 -> q=0000, q_valid still 1.
REQ-034 Scan: mode=1, scan_start 1 cycle -> q_sel 0,1,2,3 on four consecutive edges with matching q, scan_busy high 4 cycles, scan_done one cycle after last sample, then q_valid=0, q holds {D4,44}.
REQ-035 Abort: start scan, drop mode at cnt=1 -> no scan_done, scan_busy=0, direct output from sel_r next edge.
REQ-036 Reset mid-scan at cnt=2 -> all outputs 0 next edge; scan_start after release -> fresh pass from q_sel=0.
REQ-037 scan_start held high continuously -> passes separated by one IDLE cycle, scan_done once per pass.
